// File: rtl/pc_stack_pkg.sv
// Shared HACK constants and the per-edge operation decode for the PC/return-stack.
// The decode is kept here so the priority order lives in one place.
package pc_stack_pkg;

  localparam int HACK_ADDR_W    = 15;
  localparam int PC_STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_HOLD     = 3'd0,
    OP_INC      = 3'd1,
    OP_LOAD     = 3'd2,
    OP_CALL     = 3'd3,
    OP_RET      = 3'd4,
    OP_CALL_OVF = 3'd5,
    OP_RET_UNF  = 3'd6
  } pc_op_t;

  // push&pop together is a plain jump; refused push/pop only raise a sticky flag.
  function automatic pc_op_t pc_decode(
    input logic push,
    input logic pop,
    input logic load,
    input logic inc,
    input logic full,
    input logic empty
  );
    pc_op_t op;
    op = OP_HOLD;
    if (push && pop) begin
      op = OP_LOAD;
    end else if (pop) begin
      op = empty ? OP_RET_UNF : OP_RET;
    end else if (push) begin
      op = full ? OP_CALL_OVF : OP_CALL;
    end else if (load) begin
      op = OP_LOAD;
    end else if (inc) begin
      op = OP_INC;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_lifo_mem.sv
// Return-address storage: DEPTH x WIDTH register array, synchronous write and
// combinational read. Contents are not reset; the depth pointer defines validity.
module lifo_mem #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/pc_stack.sv
// HACK program counter with a hardware return-address stack for call/return.
// Only the depth pointer tracks the LIFO; full/empty are decoded from it.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = HACK_ADDR_W,
  parameter int DEPTH = PC_STACK_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] depth,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] r_pc;
  logic [CNT_W-1:0] r_depth;
  logic             r_overflow;
  logic             r_underflow;

  pc_op_t           w_op;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_top;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_full   = (r_depth == CNT_W'(DEPTH));
  assign w_empty  = (r_depth == '0);
  assign w_pc_inc = r_pc + WIDTH'(1);
  assign w_op     = pc_decode(push, pop, load, inc, w_full, w_empty);

  // Write slot is the current depth; read slot is the entry just below it.
  assign w_wr_en  = rst_n && (w_op == OP_CALL);
  assign w_wr_idx = IDX_W'(r_depth);
  assign w_rd_idx = IDX_W'(r_depth - CNT_W'(1));

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (w_pc_inc),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_top)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (w_op)
        OP_INC: begin
          r_pc <= w_pc_inc;
        end
        OP_LOAD: begin
          r_pc <= in;
        end
        OP_CALL: begin
          r_pc    <= in;
          r_depth <= r_depth + CNT_W'(1);
        end
        OP_RET: begin
          r_pc    <= w_top;
          r_depth <= r_depth - CNT_W'(1);
        end
        OP_CALL_OVF: begin
          r_overflow <= 1'b1;
        end
        OP_RET_UNF: begin
          r_underflow <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out       = r_pc;
  assign depth     = r_depth;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_pc_stack;

  localparam int WIDTH = 15;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] depth;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  int n_checks;
  int n_fail;

  // Reference model: PC value, return-address queue, sticky flags.
  int               pc_m;
  bit               of_m;
  bit               uf_m;
  logic [WIDTH-1:0] exp_q[$];

  pc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .load      (load),
    .inc       (inc),
    .push      (push),
    .pop       (pop),
    .out       (out),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input int a, input bit ld, input bit ic,
                            input bit ps, input bit pp);
    if (!r) begin
      pc_m = 0;
      exp_q.delete();
      of_m = 0;
      uf_m = 0;
    end else if (ps && pp) begin
      pc_m = a;
    end else if (pp) begin
      if (exp_q.size() == 0) uf_m = 1;
      else pc_m = int'(exp_q.pop_back());
    end else if (ps) begin
      if (exp_q.size() == DEPTH) begin
        of_m = 1;
      end else begin
        exp_q.push_back(WIDTH'((pc_m + 1) & MASK));
        pc_m = a;
      end
    end else if (ld) begin
      pc_m = a;
    end else if (ic) begin
      pc_m = (pc_m + 1) & MASK;
    end
  endtask

  task automatic check_all();
    check_eq("out",       32'(out),       32'(pc_m));
    check_eq("depth",     32'(depth),     32'(exp_q.size()));
    check_eq("full",      32'(full),      32'(exp_q.size() == DEPTH));
    check_eq("empty",     32'(empty),     32'(exp_q.size() == 0));
    check_eq("overflow",  32'(overflow),  32'(of_m));
    check_eq("underflow", 32'(underflow), 32'(uf_m));
  endtask

  // Driver: apply one cycle of controls, advance model, check after the edge.
  task automatic drive(input bit r, input int a, input bit ld, input bit ic,
                       input bit ps, input bit pp);
    @(negedge clk);
    rst_n = r;
    in    = WIDTH'(a);
    load  = ld;
    inc   = ic;
    push  = ps;
    pop   = pp;
    model_step(r, a & MASK, ld, ic, ps, pp);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive_random(input int n);
    for (int i = 0; i < n; i++) begin
      int c;
      c = $urandom_range(0, 15);
      drive($urandom_range(0, 39) != 0, $urandom_range(0, MASK),
            c[0], c[1], c[2], c[3]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pc_m = 0; of_m = 0; uf_m = 0;
    rst_n = 1'b0; in = '0; load = 0; inc = 0; push = 0; pop = 0;

    drive(0, 0, 0, 0, 0, 0);
    drive_random(40);

    // Reset after random activity
    drive(0, 0, 1, 1, 1, 0);
    check_eq("t1_out", 32'(out), 32'h0);
    check_eq("t1_empty", 32'(empty), 32'h1);

    // Load, increment, wrap
    drive(1, 'h0100, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0, 0);
    check_eq("t2_inc", 32'(out), 32'h0103);
    drive(1, 'h7FFF, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    check_eq("t2_wrap", 32'(out), 32'h0000);

    // Single call / return
    drive(1, 'h0010, 1, 0, 0, 0);
    drive(1, 'h0200, 0, 0, 1, 0);
    check_eq("t3_call", 32'(out), 32'h0200);
    drive(1, 0, 0, 0, 0, 1);
    check_eq("t3_ret", 32'(out), 32'h0011);

    // Overflow and underflow
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 'h1000, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) drive(1, i * 'h100, 0, 0, 1, 0);
    check_eq("t4_ovf_out", 32'(out), 32'h0800);
    check_eq("t4_ovf_flag", 32'(overflow), 32'h1);
    drive(1, 0, 0, 0, 0, 1);
    check_eq("t4_first_ret", 32'(out), 32'h0701);
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 0, 1);
    check_eq("t4_last_ret", 32'(out), 32'h1001);
    drive(1, 0, 0, 0, 0, 1);
    check_eq("t4_unf_flag", 32'(underflow), 32'h1);
    check_eq("t4_unf_out", 32'(out), 32'h1001);

    // push&pop acts as a jump; load beats inc
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 'h0010, 0, 0, 1, 0);
    drive(1, 'h0020, 0, 0, 1, 0);
    drive(1, 'h0444, 0, 0, 1, 1);
    check_eq("t5_jump_out", 32'(out), 32'h0444);
    check_eq("t5_jump_depth", 32'(depth), 32'h2);
    drive(1, 'h0050, 1, 1, 0, 0);
    check_eq("t5_load_inc", 32'(out), 32'h0050);

    // Reset mid-sequence discards the stack
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 'h0300 + i, 0, 0, 1, 0);
    drive(0, 'h0123, 0, 0, 1, 0);
    check_eq("t6_depth", 32'(depth), 32'h0);
    drive(1, 0, 0, 0, 0, 1);
    check_eq("t6_unf", 32'(underflow), 32'h1);

    drive_random(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
